qq_seq_ctrl: RTL and testbench

QQ_SEQ_CTRL -- requirements
Module: qq_seq_ctrl

---
 rtl/qq_seq_ctrl.sv | 256 +++++++++++++++++++++++++
 tb/tb_qq_seq_ctrl.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/qq_seq_ctrl.sv
// Sorted-insertion priority queue controller over an external single-port BRAM.
// Optional head cache (head_valid/head_data) is enabled with `define QQ_HEAD_CACHE_EN.
module qq_seq_ctrl #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  input  logic              cmd_op,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              cmd_ready,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [DATA_W-1:0] resp_data,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [DATA_W-1:0] rt_reg_data,
  output logic [DATA_W-1:0] rt_ram_data,
  input  logic [DATA_W-1:0] rt_data_out,
  input  logic              rt_fb
`ifdef QQ_HEAD_CACHE_EN
  ,
  output logic              head_valid,
  output logic [DATA_W-1:0] head_data
`endif
);

  localparam logic [3:0] IDLE    = 4'd0;
  localparam logic [3:0] ENQ_RD  = 4'd1;
  localparam logic [3:0] ENQ_CMP = 4'd2;
  localparam logic [3:0] ENQ_APP = 4'd3;
  localparam logic [3:0] DEQ_RD0 = 4'd4;
  localparam logic [3:0] DEQ_CAP = 4'd5;
  localparam logic [3:0] DEQ_RD  = 4'd6;
  localparam logic [3:0] DEQ_WR  = 4'd7;
  localparam logic [3:0] RESP    = 4'd8;

  localparam logic [ADDR_W:0] ZERO_C = '0;
  localparam logic [ADDR_W:0] ONE_C  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] FULL_C = (ADDR_W+1)'(DEPTH);

  logic [3:0]        state_r, state_s;
  logic [ADDR_W:0]   idx_r, idx_s, idx_m1_s;
  logic [DATA_W-1:0] carry_r, carry_s;
  logic [ADDR_W:0]   count_r, count_s;
  logic [DATA_W-1:0] resp_data_r, resp_data_s;
  logic              cmd_ready_r, resp_valid_r, resp_err_r, err_s;
  logic              ram_en_r, ram_we_r, ram_en_s, ram_we_s;
  logic [ADDR_W-1:0] ram_addr_r, ram_addr_s;
  logic [DATA_W-1:0] ram_wdata_s;
  logic              full_s, empty_s, accept_s;

  assign full_s   = (count_r == FULL_C);
  assign empty_s  = (count_r == ZERO_C);
  assign accept_s = cmd_valid & cmd_ready_r & (state_r == IDLE);

  // Next-state, index, carry and occupancy update
  always_comb begin
    state_s     = state_r;
    idx_s       = idx_r;
    carry_s     = carry_r;
    count_s     = count_r;
    resp_data_s = resp_data_r;
    err_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          if (cmd_op == 1'b0) begin
            if (full_s) begin
              state_s = RESP;
              err_s   = 1'b1;
            end else begin
              carry_s = cmd_data;
              idx_s   = ZERO_C;
              state_s = empty_s ? ENQ_APP : ENQ_RD;
            end
          end else begin
            if (empty_s) begin
              state_s = RESP;
              err_s   = 1'b1;
            end else begin
              idx_s   = ZERO_C;
              state_s = DEQ_RD0;
            end
          end
        end else begin
          state_s = IDLE;
        end
      end
      ENQ_RD:  state_s = ENQ_CMP;
      ENQ_CMP: begin
        // Router keeps the larger value travelling up; the smaller one stays at i.
        carry_s = rt_data_out;
        idx_s   = idx_r + ONE_C;
        state_s = ((idx_r + ONE_C) == count_r) ? ENQ_APP : ENQ_RD;
      end
      ENQ_APP: begin
        count_s = count_r + ONE_C;
        state_s = RESP;
      end
      DEQ_RD0: state_s = DEQ_CAP;
      DEQ_CAP: begin
        resp_data_s = ram_rdata;
        idx_s       = ONE_C;
        if (count_r == ONE_C) begin
          count_s = count_r - ONE_C;
          state_s = RESP;
        end else begin
          state_s = DEQ_RD;
        end
      end
      DEQ_RD:  state_s = DEQ_WR;
      DEQ_WR: begin
        idx_s = idx_r + ONE_C;
        if ((idx_r + ONE_C) == count_r) begin
          count_s = count_r - ONE_C;
          state_s = RESP;
        end else begin
          state_s = DEQ_RD;
        end
      end
      RESP:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  assign idx_m1_s = idx_s - ONE_C;

  // BRAM control decoded from the upcoming state so it is registered into that state
  always_comb begin
    ram_en_s   = 1'b0;
    ram_we_s   = 1'b0;
    ram_addr_s = '0;
    case (state_s)
      ENQ_RD: begin
        ram_en_s   = 1'b1;
        ram_addr_s = idx_s[ADDR_W-1:0];
      end
      ENQ_CMP: begin
        ram_en_s   = 1'b1;
        ram_we_s   = 1'b1;
        ram_addr_s = idx_s[ADDR_W-1:0];
      end
      ENQ_APP: begin
        ram_en_s   = 1'b1;
        ram_we_s   = 1'b1;
        ram_addr_s = count_s[ADDR_W-1:0];
      end
      DEQ_RD0: begin
        ram_en_s   = 1'b1;
        ram_addr_s = '0;
      end
      DEQ_RD: begin
        ram_en_s   = 1'b1;
        ram_addr_s = idx_s[ADDR_W-1:0];
      end
      DEQ_WR: begin
        ram_en_s   = 1'b1;
        ram_we_s   = 1'b1;
        ram_addr_s = idx_m1_s[ADDR_W-1:0];
      end
      default: begin
        ram_en_s   = 1'b0;
        ram_we_s   = 1'b0;
        ram_addr_s = '0;
      end
    endcase
  end

  // Write data depends on read data returned this cycle, so it cannot be registered
  always_comb begin
    case (state_r)
      ENQ_CMP: ram_wdata_s = rt_fb ? carry_r : ram_rdata;
      ENQ_APP: ram_wdata_s = carry_r;
      DEQ_WR:  ram_wdata_s = ram_rdata;
      default: ram_wdata_s = '0;
    endcase
  end

  // Controller state and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      idx_r        <= '0;
      carry_r      <= '0;
      count_r      <= '0;
      resp_data_r  <= '0;
      cmd_ready_r  <= 1'b0;
      resp_valid_r <= 1'b0;
      resp_err_r   <= 1'b0;
      ram_en_r     <= 1'b0;
      ram_we_r     <= 1'b0;
      ram_addr_r   <= '0;
    end else begin
      state_r      <= state_s;
      idx_r        <= idx_s;
      carry_r      <= carry_s;
      count_r      <= count_s;
      resp_data_r  <= resp_data_s;
      cmd_ready_r  <= (state_s == IDLE);
      resp_valid_r <= (state_s == RESP);
      resp_err_r   <= err_s;
      ram_en_r     <= ram_en_s;
      ram_we_r     <= ram_we_s;
      ram_addr_r   <= ram_addr_s;
    end
  end

  assign cmd_ready   = cmd_ready_r;
  assign resp_valid  = resp_valid_r;
  assign resp_err    = resp_err_r;
  assign resp_data   = resp_data_r;
  assign count       = count_r;
  assign full        = full_s;
  assign empty       = empty_s;
  assign ram_en      = ram_en_r;
  assign ram_we      = ram_we_r;
  assign ram_addr    = ram_addr_r;
  assign ram_wdata   = ram_wdata_s;
  assign rt_reg_data = carry_r;
  assign rt_ram_data = ram_rdata;

`ifdef QQ_HEAD_CACHE_EN
  logic              head_valid_r;
  logic [DATA_W-1:0] head_data_r;

  // Head tracks BRAM address 0: min on insert, the shifted-down entry on removal
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_valid_r <= 1'b0;
      head_data_r  <= '0;
    end else if (accept_s && (cmd_op == 1'b0) && !full_s) begin
      head_valid_r <= 1'b1;
      if (!head_valid_r || (cmd_data < head_data_r)) begin
        head_data_r <= cmd_data;
      end
    end else if ((state_r == DEQ_CAP) && (count_r == ONE_C)) begin
      head_valid_r <= 1'b0;
    end else if ((state_r == DEQ_WR) && (idx_r == ONE_C)) begin
      head_data_r <= ram_rdata;
    end
  end

  assign head_valid = head_valid_r;
  assign head_data  = head_data_r;
`endif

endmodule

// File: tb/tb_qq_seq_ctrl.sv
// Self-checking bench for qq_seq_ctrl: BRAM and router models, sorted-queue reference,
// vector table, hand-written timing/reset sequences and a randomized phase.
module tb_qq_seq_ctrl;
  localparam int DW = 16;
  localparam int DP = 16;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid, cmd_op;
  logic [DW-1:0] cmd_data;
  logic          cmd_ready, resp_valid, resp_err;
  logic [DW-1:0] resp_data;
  logic [AW:0]   count;
  logic          full, empty, ram_en, ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata, ram_rdata, rt_reg_data, rt_ram_data, rt_data_out;
  logic          rt_fb;
`ifdef QQ_HEAD_CACHE_EN
  logic          head_valid;
  logic [DW-1:0] head_data;
`endif

  qq_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_data(cmd_data),
    .cmd_ready(cmd_ready), .resp_valid(resp_valid), .resp_err(resp_err), .resp_data(resp_data),
    .count(count), .full(full), .empty(empty), .ram_en(ram_en), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .rt_reg_data(rt_reg_data), .rt_ram_data(rt_ram_data), .rt_data_out(rt_data_out), .rt_fb(rt_fb)
`ifdef QQ_HEAD_CACHE_EN
    , .head_valid(head_valid), .head_data(head_data)
`endif
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [DP];
  logic [DW-1:0] rdata_q = '0;
  int            we_cnt = 0;

  // One-cycle-latency BRAM plus a write counter
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else rdata_q <= mem[ram_addr];
    end
    if (ram_en && ram_we) we_cnt <= we_cnt + 1;
  end
  assign ram_rdata   = rdata_q;
  assign rt_data_out = (rt_reg_data > rt_ram_data) ? rt_reg_data : rt_ram_data;
  assign rt_fb       = (rt_reg_data <= rt_ram_data);

  int            n_checks = 0;
  int            n_err = 0;
  int            q[$];
  logic [DW-1:0] last_rd = '0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_mem();
    int bad = 0;
    for (int k = 0; k < q.size(); k++) if (int'(mem[k]) != q[k]) bad++;
    check("bram_sorted", bad, 0);
  endtask

  task automatic wait_ready();
    int guard = 0;
    while (!cmd_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) check("accept_timeout", guard, 0);
  endtask

  // Returns edges from acceptance until resp_valid is seen
  task automatic wait_resp(output int dly);
    int lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!resp_valid && lat < 200);
    if (!resp_valid) check("resp_timeout", lat, 0);
    dly = lat - 1;
  endtask

  task automatic run_op(input logic op, input logic [DW-1:0] data,
                        output logic err, output logic [DW-1:0] rd);
    int c, w0, dly, e_dly, e_wes, k;
    logic e_err;
    c = q.size();
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_data = data;
    wait_ready();
    w0 = we_cnt;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    wait_resp(dly);
    err = resp_err;
    rd  = resp_data;
    if (op == 1'b0) begin
      if (c == DP) begin
        e_err = 1'b1; e_dly = 0; e_wes = 0;
      end else begin
        e_err = 1'b0; e_dly = 2 * c + 1; e_wes = c + 1;
        k = 0;
        while (k < q.size() && q[k] < int'(data)) k++;
        q.insert(k, int'(data));
      end
    end else begin
      if (c == 0) begin
        e_err = 1'b1; e_dly = 0; e_wes = 0;
      end else begin
        e_err = 1'b0; e_dly = 2 * c; e_wes = c - 1;
        last_rd = 16'(q.pop_front());
      end
    end
    check("resp_err", int'(err), int'(e_err));
    check("busy_cycles", dly, e_dly);
    check("ram_writes", we_cnt - w0, e_wes);
    check("resp_data", int'(rd), int'(last_rd));
    check("count", int'(count), q.size());
    check("empty", int'(empty), int'(q.size() == 0));
    check("full", int'(full), int'(q.size() == DP));
    check_mem();
`ifdef QQ_HEAD_CACHE_EN
    @(negedge clk);
    check("head_valid", int'(head_valid), int'(q.size() != 0));
    if (q.size() != 0) check("head_data", int'(head_data), q[0]);
`endif
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0; cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    q.delete();
    last_rd = '0;
    @(negedge clk);
  endtask

  typedef struct {
    logic          op;
    logic [DW-1:0] data;
    logic          e_err;
    logic [DW-1:0] e_rd;
    int            e_cnt;
  } vec_t;

  vec_t          tbl [7];
  logic          err_o;
  logic [DW-1:0] rd_o;
  int            dly;

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{1'b0, 16'd5, 1'b0, 16'd0, 1};
    tbl[1] = '{1'b0, 16'd3, 1'b0, 16'd0, 2};
    tbl[2] = '{1'b0, 16'd9, 1'b0, 16'd0, 3};
    tbl[3] = '{1'b1, 16'd0, 1'b0, 16'd3, 2};
    tbl[4] = '{1'b1, 16'd0, 1'b0, 16'd5, 1};
    tbl[5] = '{1'b1, 16'd0, 1'b0, 16'd9, 0};
    tbl[6] = '{1'b1, 16'd0, 1'b1, 16'd9, 0};

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 1'b0; cmd_data = '0;
    #12;
    check("rst_cmd_ready", int'(cmd_ready), 0);
    check("rst_resp_valid", int'(resp_valid), 0);
    check("rst_count", int'(count), 0);
    check("rst_ram_en", int'(ram_en), 0);
    check("rst_resp_data", int'(resp_data), 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_release", int'(cmd_ready), 1);

    for (int i = 0; i < 7; i++) begin
      run_op(tbl[i].op, tbl[i].data, err_o, rd_o);
      check("tbl_err", int'(err_o), int'(tbl[i].e_err));
      check("tbl_rd", int'(rd_o), int'(tbl[i].e_rd));
      check("tbl_count", int'(count), tbl[i].e_cnt);
      if (i == 2) begin
        check("tbl_bram0", int'(mem[0]), 3);
        check("tbl_bram1", int'(mem[1]), 5);
        check("tbl_bram2", int'(mem[2]), 9);
      end
    end
    check("tbl_empty", int'(empty), 1);

    // Busy hold-off: second command held on cmd_valid through the first
    apply_reset();
    for (int k = 0; k < 4; k++) run_op(1'b0, 16'(10 * k + 7), err_o, rd_o);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 1'b0; cmd_data = 16'd20;
    wait_ready();
    @(posedge clk); #1;
    cmd_data = 16'd4;
    @(negedge clk);
    check("ready_while_busy", int'(cmd_ready), 0);
    wait_resp(dly);
    check("enq_latency_c4", dly + 1, 9);
    check("holdoff_err", int'(resp_err), 0);
    q.insert(2, 20);
    @(negedge clk);
    check("ready_first_idle", int'(cmd_ready), 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    wait_resp(dly);
    check("enq_latency_c5", dly, 11);
    q.insert(0, 4);
    check("holdoff_count", int'(count), 6);
    check_mem();

    // Reset asserted while a compare/write step is in flight
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 1'b0; cmd_data = 16'd13;
    wait_ready();
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("mid_op_write", int'(ram_we), 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_count", int'(count), 0);
    check("mid_rst_ram_en", int'(ram_en), 0);
    check("mid_rst_ready", int'(cmd_ready), 0);
    check("mid_rst_resp_valid", int'(resp_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    q.delete();
    last_rd = '0;
    @(negedge clk);
    check("post_rst_empty", int'(empty), 1);

    // Randomized mix against the sorted-queue model
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 99) < ((n < 100) ? 32'd65 : 32'd40))
        run_op(1'b0, 16'($urandom_range(0, 40)), err_o, rd_o);
      else
        run_op(1'b1, 16'd0, err_o, rd_o);
    end

    // Fill to capacity, then a rejected enqueue
    apply_reset();
    for (int k = 0; k < DP; k++) run_op(1'b0, 16'($urandom_range(0, 1000)), err_o, rd_o);
    run_op(1'b0, 16'd7, err_o, rd_o);
    check("full_reject_err", int'(err_o), 1);
    check("full_flag", int'(full), 1);
    check("full_count", int'(count), DP);

`ifdef QQ_HEAD_CACHE_EN
    apply_reset();
    run_op(1'b0, 16'd8, err_o, rd_o);
    run_op(1'b0, 16'd2, err_o, rd_o);
    check("head_after_enq", int'(head_data), 2);
    run_op(1'b1, 16'd0, err_o, rd_o);
    check("head_after_deq", int'(head_data), 8);
    run_op(1'b1, 16'd0, err_o, rd_o);
    check("head_valid_empty", int'(head_valid), 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
